// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA slices,
// each exposing its 16 gates to a per-gate stuck-at fault enable bus.
`timescale 1ns/1ps

module pipe_cla_slice (
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  input  logic        ci,
  input  logic [15:0] fen,
  input  logic        fval,
  output logic [3:0]  s,
  output logic        c3,
  output logic        c4
);
  function automatic logic fi(input logic en, input logic val, input logic x);
    return en ? val : x;
  endfunction

  logic [3:0] p_s;
  logic [3:0] g_s;
  logic [4:0] c_s;

  // Slice gates; ID order is S,P,G per bit (3i..3i+2) then C1..C4 (12..15).
  always_comb begin
    p_s = 4'b0000;
    g_s = 4'b0000;
    c_s = 5'b00000;
    s   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      p_s[i] = fi(fen[3*i+1], fval, a[i] ^ b[i]);
      g_s[i] = fi(fen[3*i+2], fval, a[i] & b[i]);
    end
    c_s[0] = ci;
    c_s[1] = fi(fen[12], fval, g_s[0] | (p_s[0] & ci));
    c_s[2] = fi(fen[13], fval, g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci));
    c_s[3] = fi(fen[14], fval, g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                             | (p_s[2] & p_s[1] & p_s[0] & ci));
    c_s[4] = fi(fen[15], fval, g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                             | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                             | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci));
    for (int i = 0; i < 4; i++) begin
      s[i] = fi(fen[3*i], fval, p_s[i] ^ c_s[i]);
    end
  end

  assign c3 = c_s[3];
  assign c4 = c_s[4];
endmodule

module pipe_cla_adder #(
  parameter int W        = 16,
  parameter int SPS      = 1,
  parameter int NG       = 128,
  parameter int GID_BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          cin,
  input  logic          sub,
  input  logic [NG-1:0] fault_en_bus,
  input  logic          fault_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  sum,
  output logic          cout,
  output logic          ovf
);
  localparam int NS = W / 4;
  localparam int L  = NS / SPS;
  localparam int SW = 4 * SPS;

  // Stage j inputs: s*_s[j]; stage j results: nsum_s[j] / nc_s[j].
  logic [W-1:0]  sa_s   [L];
  logic [W-1:0]  sb_s   [L];
  logic [W-1:0]  ssum_s [L];
  logic [W-1:0]  nsum_s [L];
  logic [L-1:0]  sc_s;
  logic [L-1:0]  sv_s;
  logic [L-1:0]  nc_s;
  logic [NS-1:0] sl_ci_s;
  logic [NS-1:0] sl_co_s;
  logic [NS-1:0] sl_c3_s;
  logic [W-1:0]  sl_sum_s;
  logic [L-1:0]  stage_unused_s;
  logic          unused_s;
  logic          adv_s;

  assign in_ready = !out_valid || out_ready;
  assign adv_s    = in_ready;

  generate
    for (genvar j = 0; j < L; j++) begin : g_st
      localparam logic [W-1:0] ONES = '1;
      localparam logic [W-1:0] MASK = (ONES >> (W - SW)) << (j * SW);

      if (j == 0) begin : g_head
        assign sa_s[0]   = a;
        assign sb_s[0]   = sub ? ~b : b;
        assign sc_s[0]   = sub ? 1'b1 : cin;
        assign ssum_s[0] = '0;
        assign sv_s[0]   = in_valid;
      end else begin : g_reg
        logic [W-1:0] a_r;
        logic [W-1:0] b_r;
        logic [W-1:0] sum_r;
        logic         c_r;
        logic         v_r;

        // Register between slice groups j-1 and j; whole pipe freezes on back-pressure.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_r   <= 1'b0;
            c_r   <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
          end else if (adv_s) begin
            v_r   <= sv_s[j-1];
            c_r   <= nc_s[j-1];
            a_r   <= sa_s[j-1];
            b_r   <= sb_s[j-1];
            sum_r <= nsum_s[j-1];
          end
        end

        assign sa_s[j]   = a_r;
        assign sb_s[j]   = b_r;
        assign sc_s[j]   = c_r;
        assign ssum_s[j] = sum_r;
        assign sv_s[j]   = v_r;
      end

      for (genvar m = 0; m < SPS; m++) begin : g_sl
        localparam int K = j * SPS + m;
        if (m == 0) begin : g_cin
          assign sl_ci_s[K] = sc_s[j];
        end else begin : g_chain
          assign sl_ci_s[K] = sl_co_s[K-1];
        end

        pipe_cla_slice u_slice (
          .a    (sa_s[j][4*K +: 4]),
          .b    (sb_s[j][4*K +: 4]),
          .ci   (sl_ci_s[K]),
          .fen  (fault_en_bus[GID_BASE + 16*K +: 16]),
          .fval (fault_val),
          .s    (sl_sum_s[4*K +: 4]),
          .c3   (sl_c3_s[K]),
          .c4   (sl_co_s[K])
        );
      end

      assign nsum_s[j]         = (ssum_s[j] & ~MASK) | (sl_sum_s & MASK);
      assign nc_s[j]           = sl_co_s[(j+1)*SPS - 1];
      assign stage_unused_s[j] = ^{sa_s[j], sb_s[j], ssum_s[j]};
    end
  endgenerate

  // Output register holding the final slice group's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv_s) begin
      out_valid <= sv_s[L-1];
      sum       <= nsum_s[L-1];
      cout      <= nc_s[L-1];
      ovf       <= sl_c3_s[NS-1] ^ sl_co_s[NS-1];
    end
  end

  // Gate IDs outside this block and already-consumed operand bits are don't-care.
  assign unused_s = ^{fault_en_bus, sl_c3_s, stage_unused_s};
endmodule
